wbu: RTL

- Write-back stage directly downstream of the load/store unit in the single-issue core.
- Accepts one instruction per cycle over the valid/ready handshake from the LSU side.
- Registers the instruction and selects the write-back value (ALU result, load data, pc+4 or CSR read data).
- Drives the register-file write port, a commit trace, a 64-bit retired-instruction counter, and a sticky halt on ebreak.

---
 rtl/wbu.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/wbu.sv
// -----------------------------------------------------------------------------
// wbu - write-back unit of the single-issue core.
//
// Sits directly after the load/store unit. Holds one instruction in a single
// register slot, picks its write-back value at capture time, and retires it
// on the following cycle. Retirement drives the register-file write port, the
// commit trace (valid + pc), a 64-bit retired-instruction counter, and a
// sticky halt flag raised when an ebreak retires.
//
// Ports
//   i_clk, i_rst        clock (rising edge), asynchronous active-high reset
//   i_pre_valid         upstream has an instruction
//   o_pre_ready         this stage can take an instruction this cycle
//   i_pc, i_rdid,
//   i_rdwen, i_ebreak   instruction attributes captured on accept
//   i_src_sel           write-back source: 00 exu, 01 load, 10 pc+4, 11 csr
//   i_exu_res, i_lsu_ld,
//   i_csr_rdata         candidate write-back values
//   o_rf_wen/waddr/wdata register-file write port
//   o_busy_rd           rd of the pending write (0 if none), for hazard logic
//   o_commit_valid      an instruction retires this cycle
//   o_commit_pc         pc of the most recently retired instruction
//   o_retired           retired-instruction count (wraps)
//   o_halt              sticky; set once an ebreak retires, cleared by reset
// -----------------------------------------------------------------------------
module wbu #(
  parameter int unsigned    CPU_WIDTH = 32,
  parameter int unsigned    REG_AW    = 5,
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,

  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_pc,
  input  logic [REG_AW-1:0]    i_rdid,
  input  logic                 i_rdwen,
  input  logic [1:0]           i_src_sel,
  input  logic [CPU_WIDTH-1:0] i_exu_res,
  input  logic [CPU_WIDTH-1:0] i_lsu_ld,
  input  logic [CPU_WIDTH-1:0] i_csr_rdata,
  input  logic                 i_ebreak,

  output logic                 o_rf_wen,
  output logic [REG_AW-1:0]    o_rf_waddr,
  output logic [CPU_WIDTH-1:0] o_rf_wdata,
  output logic [REG_AW-1:0]    o_busy_rd,

  output logic                 o_commit_valid,
  output logic [CPU_WIDTH-1:0] o_commit_pc,
  output logic [63:0]          o_retired,
  output logic                 o_halt
);

  localparam logic [1:0] SRC_EXU = 2'b00;
  localparam logic [1:0] SRC_LD  = 2'b01;
  localparam logic [1:0] SRC_PC4 = 2'b10;
  localparam logic [1:0] SRC_CSR = 2'b11;

  // Held entry
  logic                 valid_q;
  logic [CPU_WIDTH-1:0] pc_q;
  logic [REG_AW-1:0]    rdid_q;
  logic                 rdwen_q;
  logic                 ebreak_q;
  logic [CPU_WIDTH-1:0] wdata_q;

  // Architectural side state
  logic [CPU_WIDTH-1:0] commit_pc_q;
  logic [63:0]          retired_q;
  logic                 halt_q;

  logic                 accept;
  logic                 commit;
  logic [CPU_WIDTH-1:0] wdata_sel;

  // Retire whatever is held unless halted; a halted core freezes its slot.
  assign commit      = valid_q & ~halt_q;
  // Slot frees up in the same cycle it retires, so back-to-back accepts
  // sustain one instruction per cycle.
  assign o_pre_ready = ~halt_q & (~valid_q | commit);
  assign accept      = i_pre_valid & o_pre_ready;

  // Source selection happens at capture so the register-file port sees a
  // value that is already registered.
  // NOTE: every always_comb output gets a value on every path (default first)
  // so no latch is inferred.
  always_comb begin
    wdata_sel = i_exu_res;
    unique case (i_src_sel)
      SRC_EXU: wdata_sel = i_exu_res;
      SRC_LD:  wdata_sel = i_lsu_ld;
      SRC_PC4: wdata_sel = i_pc + CPU_WIDTH'(4);  // wraps at 2^CPU_WIDTH
      SRC_CSR: wdata_sel = i_csr_rdata;
      default: wdata_sel = i_exu_res;
    endcase
  end

  // Held entry: fields load only on accept; valid drops after a retire that
  // is not refilled in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      rdid_q   <= '0;
      rdwen_q  <= 1'b0;
      ebreak_q <= 1'b0;
      wdata_q  <= '0;
    end else begin
      if (accept) begin
        valid_q  <= 1'b1;
        pc_q     <= i_pc;
        rdid_q   <= i_rdid;
        rdwen_q  <= i_rdwen;
        ebreak_q <= i_ebreak;
        wdata_q  <= wdata_sel;
      end else if (commit) begin
        valid_q  <= 1'b0;
      end
    end
  end

  // Retirement bookkeeping. The ebreak itself counts as retired; from the
  // next cycle on the halt blocks both accept and commit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      commit_pc_q <= RESET_PC;
      retired_q   <= '0;
      halt_q      <= 1'b0;
    end else if (commit) begin
      commit_pc_q <= pc_q;
      retired_q   <= retired_q + 64'd1;  // wraps 2^64-1 -> 0
      if (ebreak_q) halt_q <= 1'b1;
    end
  end

  // Writes to x0 are dropped at the port, but the instruction still retires.
  assign o_commit_valid = commit;
  assign o_rf_wen       = commit & rdwen_q & (rdid_q != '0);
  assign o_rf_waddr     = rdid_q;
  assign o_rf_wdata     = wdata_q;
  assign o_busy_rd      = (valid_q & rdwen_q & ~halt_q) ? rdid_q : '0;

  assign o_commit_pc    = commit_pc_q;
  assign o_retired      = retired_q;
  assign o_halt         = halt_q;

endmodule
